uart_tx: RTL and testbench

- Serial UART transmitter, 8N1 by default, with optional parity.
- Paced by the oversampling enable tick (`s_tick`) from the existing mod-M baud tick generator; 16 ticks per bit.
- Pairs with the receive path: serialises a parallel byte from the CPU/FIFO side onto the `tx` line.
- Handshake toward the FIFO: `tx_ready` / `tx_start` / `tx_done_tick`.

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit,
// stop bit of SB_TICK oversampling ticks. Paced by a 16x baud enable.
//
// Handshake: tx_ready is high only in idle. A tx_start seen while tx_ready is
// high is accepted on that clock edge, din is captured on the same edge, and
// the start bit appears on tx from the next clock. tx_start while busy is
// dropped, not queued. tx_done_tick pulses for one clock when the stop bit
// ends, coincident with tx_ready returning high.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  // Tick counter must reach SB_TICK-1 in the stop state and 15 elsewhere.
  localparam int CW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [CW-1:0] BIT_LAST  = CW'(15);
  localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DBIT - 1);
  localparam logic          PAR_INV   = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [DBIT-1:0] shreg_q;
  logic            par_q;
  logic            tx_q;
  logic            ready_q;
  logic            done_q;

  assign tx           = tx_q;
  assign tx_ready     = ready_q;
  assign tx_done_tick = done_q;

  // Frame sequencer; tx is loaded with the level of the state being entered
  // so the line always comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          if (tx_start) begin
            shreg_q <= din;
            // Parity comes from the captured byte, not the shifting copy.
            par_q   <= (^din) ^ PAR_INV;
            tick_q  <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              bit_q   <= '0;
              tx_q    <= shreg_q[0];
              state_q <= S_DATA;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              shreg_q <= shreg_q >> 1;
              bit_q   <= bit_q + 3'd1;
              if (bit_q == DATA_LAST) begin
                if (PARITY != 0) begin
                  tx_q    <= par_q;
                  state_q <= S_PAR;
                end else begin
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
                end
              end else begin
                tx_q <= shreg_q[1];
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (s_tick) begin
            if (tick_q == STOP_LAST) begin
              tick_q  <= '0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Four instances cover no parity, even parity,
// odd parity and a two-stop-bit configuration; one is selected for observation.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       stall;
  logic [1:0] tdiv = 2'd0;
  int         cyc = 0;

  logic [3:0] st;
  logic [7:0] dn [4];
  logic [3:0] rdy;
  logic [3:0] dne;
  logic [3:0] txl;

  logic [1:0] sel;
  logic       tx_m;
  logic       rdy_m;
  logic       dne_m;

  int n_chk  = 0;
  int n_pass = 0;

  assign tx_m  = txl[sel];
  assign rdy_m = rdy[sel];
  assign dne_m = dne[sel];

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // baud enable: one pulse every 4 clocks, frozen while stall is high
  always @(posedge clk) begin
    if (stall) begin
      s_tick <= 1'b0;
    end else begin
      tdiv   <= tdiv + 2'd1;
      s_tick <= (tdiv == 2'd3);
    end
  end

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_p0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(st[0]), .din(dn[0]),
    .tx_ready(rdy[0]), .tx_done_tick(dne[0]), .tx(txl[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_pe (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(st[1]), .din(dn[1]),
    .tx_ready(rdy[1]), .tx_done_tick(dne[1]), .tx(txl[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_po (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(st[2]), .din(dn[2]),
    .tx_ready(rdy[2]), .tx_done_tick(dne[2]), .tx(txl[2]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(st[3]), .din(dn[3]),
    .tx_ready(rdy[3]), .tx_done_tick(dne[3]), .tx(txl[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance n baud ticks, sampling at falling edges
  task automatic wait_ticks(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n) begin
      @(negedge clk);
      if (s_tick) seen++;
      guard++;
      if (guard > n * 8 + 64) begin
        check("tick_timeout", 0, 1);
        return;
      end
    end
  endtask

  // pulse tx_start for one clock on instance s; caller is at a falling edge
  task automatic start_frame(input logic [1:0] s, input logic [7:0] d, output int acc_cyc);
    sel   = s;
    dn[s] = d;
    st[s] = 1'b1;
    @(negedge clk);
    st[s]   = 1'b0;
    dn[s]   = ~d;
    acc_cyc = cyc;
    check("accept_tx_low", tx_m, 0);
    check("accept_ready_low", rdy_m, 0);
  endtask

  // sample each bit near its middle; optionally freeze ticks inside one data bit
  task automatic recv_frame(input logic [7:0] d, input int pmode, input logic exp_par,
                            input int stall_bit, output int done_cyc);
    logic hold;
    int   changes;
    int   guard;
    wait_ticks(8);
    check("start_bit", tx_m, 0);
    check("busy_ready", rdy_m, 0);
    for (int i = 0; i < 8; i++) begin
      wait_ticks(16);
      check("data_bit", tx_m, d[i]);
      if (i == stall_bit) begin
        stall   = 1'b1;
        hold    = tx_m;
        changes = 0;
        repeat (100) begin
          @(negedge clk);
          if (tx_m !== hold) changes++;
        end
        check("stall_hold", changes, 0);
        check("stall_ready", rdy_m, 0);
        stall = 1'b0;
      end
    end
    if (pmode != 0) begin
      wait_ticks(16);
      check("parity_bit", tx_m, exp_par);
    end
    wait_ticks(16);
    check("stop_bit", tx_m, 1);
    check("stop_ready", rdy_m, 0);
    guard = 0;
    while (!dne_m && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", dne_m, 1);
    done_cyc = cyc;
    check("done_ready", rdy_m, 1);
    @(negedge clk);
    check("done_single", dne_m, 0);
  endtask

  // count clocks in a window where the selected line must stay idle
  task automatic quiet_window(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || rdy_m !== 1'b1 || dne_m !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    int a2;
    int dc;
    reset = 1'b1;
    stall = 1'b0;
    st    = '0;
    sel   = 2'd0;
    for (int i = 0; i < 4; i++) dn[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_tx", tx_m, 1);
    check("rst_ready", rdy_m, 1);
    check("rst_done", dne_m, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_tx", tx_m, 1);
    check("idle_ready", rdy_m, 1);

    // basic 8N1 frame, 0xA5: line 0,1,0,1,0,0,1,0,1,1
    start_frame(2'd0, 8'hA5, a);
    recv_frame(8'hA5, 0, 1'b0, -1, dc);
    check("len_8n1", ((dc - a) >= 636 && (dc - a) <= 644), 1);

    // parity frames
    @(negedge clk);
    start_frame(2'd1, 8'hA5, a);
    recv_frame(8'hA5, 1, 1'b0, -1, dc);
    check("len_8e1", ((dc - a) >= 700 && (dc - a) <= 708), 1);
    @(negedge clk);
    start_frame(2'd2, 8'hA5, a);
    recv_frame(8'hA5, 2, 1'b1, -1, dc);
    @(negedge clk);
    start_frame(2'd1, 8'h07, a);
    recv_frame(8'h07, 1, 1'b1, -1, dc);

    // two stop bits: 9 bits of 64 clk plus 128 clk of stop
    @(negedge clk);
    start_frame(2'd3, 8'h55, a);
    recv_frame(8'h55, 0, 1'b0, -1, dc);
    check("len_sb32", ((dc - a) >= 700 && (dc - a) <= 708), 1);

    // busy rejection: request 0x3C mid-frame of 0x55
    @(negedge clk);
    start_frame(2'd0, 8'h55, a);
    fork
      recv_frame(8'h55, 0, 1'b0, -1, dc);
      begin
        wait_ticks(8 + 16 * 4);
        dn[0] = 8'h3C;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
      end
    join
    quiet_window("no_queued_frame", 800);

    // back-to-back 0x00 then 0xFF
    start_frame(2'd0, 8'h00, a);
    recv_frame(8'h00, 0, 1'b0, -1, dc);
    start_frame(2'd0, 8'hFF, a2);
    check("b2b_gap", ((a2 - dc) <= 4), 1);
    recv_frame(8'hFF, 0, 1'b0, -1, dc);

    // reset during data bit 3
    @(negedge clk);
    start_frame(2'd0, 8'h5A, a);
    wait_ticks(8 + 16 * 4);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx_m, 1);
    check("midrst_ready", rdy_m, 1);
    check("midrst_done", dne_m, 0);
    reset = 1'b0;
    quiet_window("midrst_quiet", 800);
    start_frame(2'd0, 8'h81, a);
    recv_frame(8'h81, 0, 1'b0, -1, dc);

    // stall ticks for 100 clk inside data bit 3 of 0xF0
    @(negedge clk);
    start_frame(2'd0, 8'hF0, a);
    recv_frame(8'hF0, 0, 1'b0, 3, dc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
